load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for the EX/MEM stage.
// Issues one memory transaction at a time on a simple req/ack bus and stalls the upstream
// stages until it completes. Loads are byte-lane extracted and sign/zero extended. Stores
// replicate data across lanes with matching byte enables. Misaligned accesses, illegal
// Funct3 codes and ack timeouts raise a one-cycle Fault.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   Valid, MemRead, MemWrite       live instruction and access type (MemWrite wins)
//   Funct3                         access size/sign (B, H, W, BU, HU)
//   ALUResult, WriteData           byte address and right-aligned store data
//   Flush                          discard the result of the current access
//   Stall                          freeze upstream stages
//   ReadData, LoadValid            extended load result and its one-cycle qualifier
//   Fault, FaultCause              one-cycle fault pulse; 01 misaligned, 10 illegal, 11 timeout
//   mem_req/we/addr/be/wdata       memory request, held while the transaction is in flight
//   mem_ack, mem_rdata             memory completion and load data
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Valid,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  Flush,
  output logic                  Stall,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  LoadValid,
  output logic                  Fault,
  output logic [1:0]            FaultCause,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q;
  logic [CntWidth-1:0]     cnt_q;
  logic                    drop_q;
  logic                    is_load_q;
  logic [2:0]              f3_q;
  logic [1:0]              off_q;
  logic                    mem_we_q;
  logic [3:0]              mem_be_q;
  logic [DATA_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [DATA_WIDTH-1:0]   read_data_q;
  logic                    load_valid_q;

  logic is_store, access, illegal, misalign, in_idle, busy, start, idle_fault, timeout, to_fault;

  assign is_store = MemWrite;
  assign access   = Valid & (MemRead | MemWrite) & ~Flush;
  // 011/110/111 never legal; unsigned sizes are load-only.
  assign illegal  = (Funct3[1:0] == 2'b11) | (Funct3[2] & Funct3[1]) | (is_store & Funct3[2]);
  assign misalign = ((Funct3[1:0] == 2'b01) & ALUResult[0]) |
                    ((Funct3[1:0] == 2'b10) & (ALUResult[1:0] != 2'b00));

  assign in_idle    = (state_q == StIdle);
  assign busy       = (state_q == StBusy);
  // rst_n gating keeps the combinational outputs quiet while reset is held.
  assign start      = rst_n & in_idle & access & ~illegal & ~misalign;
  assign idle_fault = rst_n & in_idle & access & (illegal | misalign);
  // Last permitted BUSY cycle without an ack: give up and release the pipeline now.
  assign timeout    = busy & ~mem_ack & (cnt_q == CntLast);
  assign to_fault   = timeout & ~drop_q & ~Flush;

  assign Stall = start | (busy & ~mem_ack & ~timeout);
  assign Fault = idle_fault | to_fault;

  always_comb begin
    FaultCause = 2'b00;
    if (to_fault) begin
      FaultCause = 2'b11;
    end else if (idle_fault) begin
      FaultCause = illegal ? 2'b10 : 2'b01;
    end
  end

  // Store lane steering.
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ALUResult[1:0];
        st_wdata = {(DATA_WIDTH / 8){WriteData[7:0]}};
      end
      2'b01: begin
        st_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        st_wdata = {(DATA_WIDTH / 16){WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction uses the offset and size latched at start.
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  sext;
  logic [DATA_WIDTH-1:0] load_ext;

  assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = mem_rdata[{off_q[1], 4'b0000} +: 16];
  assign sext     = ~f3_q[2];

  always_comb begin
    load_ext = mem_rdata;
    case (f3_q[1:0])
      2'b00:   load_ext = {{(DATA_WIDTH - 8){sext & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{(DATA_WIDTH - 16){sext & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
      is_load_q    <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      read_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StBusy;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            is_load_q   <= ~is_store;
            f3_q        <= Funct3;
            off_q       <= ALUResult[1:0];
            mem_we_q    <= is_store;
            mem_be_q    <= is_store ? st_be : 4'b0000;
            mem_addr_q  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_q <= st_wdata;
          end
        end
        StBusy: begin
          if (mem_ack) begin
            state_q  <= StIdle;
            mem_we_q <= 1'b0;
            mem_be_q <= 4'b0000;
            if (is_load_q && !drop_q && !Flush) begin
              read_data_q  <= load_ext;
              load_valid_q <= 1'b1;
            end
          end else if (timeout) begin
            state_q  <= StIdle;
            mem_we_q <= 1'b0;
            mem_be_q <= 4'b0000;
          end else begin
            cnt_q <= cnt_q + CntWidth'(1);
            if (Flush) drop_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_req   = busy;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ReadData  = read_data_q;
  assign LoadValid = load_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: reset, loads, stores, faults, timeout, flush and
// reset during a transaction. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Valid, MemRead, MemWrite, Flush;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Stall, LoadValid, Fault;
  logic [31:0] ReadData;
  logic [1:0]  FaultCause;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALUResult(ALUResult), .WriteData(WriteData), .Flush(Flush),
    .Stall(Stall), .ReadData(ReadData), .LoadValid(LoadValid), .Fault(Fault),
    .FaultCause(FaultCause), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic idle_in();
    Valid = 0; MemRead = 0; MemWrite = 0; Funct3 = 3'b000; ALUResult = '0;
    WriteData = '0; Flush = 0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a load and acks it after 'wait_cycles' BUSY cycles; returns just after the edge
  // that registers the result, with inputs idle.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata, input int wait_cycles);
    Valid = 1; MemRead = 1; Funct3 = f3; ALUResult = addr;
    step();
    repeat (wait_cycles) step();
    mem_ack = 1; mem_rdata = rdata;
    step();
    idle_in();
  endtask

  task automatic test_reset();
    idle_in();
    Valid = 1; MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h6;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_be, Stall, LoadValid} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000000", {mem_req, mem_we, mem_be, Stall, LoadValid});
    end
    checks++;
    if ({Fault, FaultCause} !== 3'b000) begin
      failures++;
      $display("FAIL reset_fault got=%b exp=000", {Fault, FaultCause});
    end
    checks++;
    if (ReadData !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=00000000", ReadData);
    end
    idle_in();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_lb();
    stall_cnt = 0;
    Valid = 1; MemRead = 1; Funct3 = 3'b000; ALUResult = 32'h1003;
    @(negedge clk); if (Stall) stall_cnt++;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL lb_req_at_start got=%b exp=0", mem_req);
    end
    step();
    @(negedge clk); if (Stall) stall_cnt++;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h1000}) begin
      failures++;
      $display("FAIL lb_bus got=%b/%b/%b/%h exp=1/0/0000/00001000", mem_req, mem_we, mem_be, mem_addr);
    end
    step();
    @(negedge clk); if (Stall) stall_cnt++;
    step();
    mem_ack = 1; mem_rdata = 32'h80FF_1234;
    @(negedge clk); if (Stall) stall_cnt++;
    checks++;
    if (LoadValid !== 1'b0) begin
      failures++; $display("FAIL lb_early_valid got=%b exp=0", LoadValid);
    end
    step();
    idle_in();
    @(negedge clk);
    checks++;
    if ({LoadValid, ReadData, mem_req} !== {1'b1, 32'hFFFF_FF80, 1'b0}) begin
      failures++;
      $display("FAIL lb_result got=%b/%h/%b exp=1/ffffff80/0", LoadValid, ReadData, mem_req);
    end
    checks++;
    if (stall_cnt !== 3) begin
      failures++; $display("FAIL lb_stall_cycles got=%0d exp=3", stall_cnt);
    end
    step();
    @(negedge clk);
    checks++;
    if ({LoadValid, ReadData} !== {1'b0, 32'hFFFF_FF80}) begin
      failures++; $display("FAIL lb_hold got=%b/%h exp=0/ffffff80", LoadValid, ReadData);
    end
  endtask

  task automatic test_sh();
    stall_cnt = 0;
    Valid = 1; MemWrite = 1; Funct3 = 3'b001; ALUResult = 32'h2002; WriteData = 32'h0000_ABCD;
    @(negedge clk); if (Stall) stall_cnt++;
    step();
    mem_ack = 1;
    @(negedge clk); if (Stall) stall_cnt++;
    checks++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b1, 4'b1100, 32'h2000}) begin
      failures++;
      $display("FAIL sh_bus got=%b/%b/%b/%h exp=1/1/1100/00002000", mem_req, mem_we, mem_be, mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'hABCD_ABCD) begin
      failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", mem_wdata);
    end
    step();
    idle_in();
    @(negedge clk);
    checks++;
    if ({mem_req, LoadValid} !== 2'b00 || stall_cnt !== 1) begin
      failures++;
      $display("FAIL sh_done got=req%b/lv%b/stall%0d exp=0/0/1", mem_req, LoadValid, stall_cnt);
    end
  endtask

  task automatic test_faults();
    logic [2:0] f3s [4] = '{3'b010, 3'b100, 3'b011, 3'b101};
    logic       wrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ads [4] = '{32'h6, 32'h0, 32'h1, 32'h2};
    logic [1:0] cause [4] = '{2'b01, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 4; i++) begin
      // Case 3 sets both MemRead and MemWrite: the store wins, so HU is illegal.
      Valid = 1; MemRead = (i != 1); MemWrite = wrs[i]; Funct3 = f3s[i]; ALUResult = ads[i];
      @(negedge clk);
      checks++;
      if ({Fault, FaultCause, Stall, mem_req} !== {1'b1, cause[i], 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL fault_%0d got=%b exp=%b", i, {Fault, FaultCause, Stall, mem_req},
                 {1'b1, cause[i], 1'b0, 1'b0});
      end
      step();
      idle_in();
      @(negedge clk);
      checks++;
      if ({Fault, mem_req} !== 2'b00) begin
        failures++; $display("FAIL fault_%0d_after got=%b exp=00", i, {Fault, mem_req});
      end
    end
    run_load(3'b101, 32'h6, 32'h8001_0000, 0);
    @(negedge clk);
    checks++;
    if ({LoadValid, ReadData} !== {1'b1, 32'h0000_8001}) begin
      failures++; $display("FAIL lhu got=%b/%h exp=1/00008001", LoadValid, ReadData);
    end
  endtask

  task automatic test_patterns();
    logic [2:0]  f3s [4] = '{3'b001, 3'b100, 3'b000, 3'b010};
    logic [31:0] ads [4] = '{32'h2, 32'h1, 32'h0, 32'h4};
    logic [31:0] rds [4] = '{32'h8001_7FFF, 32'h0000_C300, 32'h0000_007F, 32'h1234_5678};
    logic [31:0] exs [4] = '{32'hFFFF_8001, 32'h0000_00C3, 32'h0000_007F, 32'h1234_5678};
    for (int i = 0; i < 4; i++) begin
      run_load(f3s[i], ads[i], rds[i], i % 2);
      @(negedge clk);
      checks++;
      if ({LoadValid, ReadData} !== {1'b1, exs[i]}) begin
        failures++; $display("FAIL load_%0d got=%b/%h exp=1/%h", i, LoadValid, ReadData, exs[i]);
      end
    end
    // SB at offset 1
    Valid = 1; MemWrite = 1; Funct3 = 3'b000; ALUResult = 32'h11; WriteData = 32'h1234_56A5;
    step();
    mem_ack = 1;
    @(negedge clk);
    checks++;
    if ({mem_be, mem_wdata, mem_addr} !== {4'b0010, 32'hA5A5_A5A5, 32'h10}) begin
      failures++;
      $display("FAIL sb got=%b/%h/%h exp=0010/a5a5a5a5/00000010", mem_be, mem_wdata, mem_addr);
    end
    step();
    idle_in();
    // SW
    Valid = 1; MemWrite = 1; Funct3 = 3'b010; ALUResult = 32'h20; WriteData = 32'hDEAD_BEEF;
    step();
    mem_ack = 1;
    @(negedge clk);
    checks++;
    if ({mem_we, mem_be, mem_wdata} !== {1'b1, 4'b1111, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL sw got=%b/%b/%h exp=1/1111/deadbeef", mem_we, mem_be, mem_wdata);
    end
    step();
    idle_in();
  endtask

  task automatic test_timeout();
    Valid = 1; MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h40;
    step();
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (i < 16) begin
        if ({mem_req, Stall, Fault} !== 3'b110) begin
          failures++;
          $display("FAIL timeout_wait_%0d got=%b exp=110", i, {mem_req, Stall, Fault});
        end
        step();
      end else if ({Stall, Fault, FaultCause} !== 4'b0111) begin
        failures++;
        $display("FAIL timeout_fire got=%b exp=0111", {Stall, Fault, FaultCause});
      end
    end
    step();
    idle_in();
    @(negedge clk);
    checks++;
    if ({mem_req, LoadValid, Fault, Stall} !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_after got=%b exp=0000", {mem_req, LoadValid, Fault, Stall});
    end
    step();
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 0;
    @(negedge clk);
    checks++;
    if ({LoadValid, ReadData} !== {1'b0, 32'h1234_5678}) begin
      failures++; $display("FAIL stray_ack got=%b/%h exp=0/12345678", LoadValid, ReadData);
    end
  endtask

  task automatic test_flush();
    Valid = 1; MemRead = 1; Funct3 = 3'b100; ALUResult = 32'h3;
    step();
    step();
    Flush = 1;
    @(negedge clk);
    checks++;
    if ({mem_req, Stall, Fault} !== 3'b110) begin
      failures++; $display("FAIL flush_busy got=%b exp=110", {mem_req, Stall, Fault});
    end
    step();
    Flush = 0; mem_ack = 1; mem_rdata = 32'hAB00_0000;
    @(negedge clk);
    checks++;
    if (Stall !== 1'b0) begin
      failures++; $display("FAIL flush_ack_stall got=%b exp=0", Stall);
    end
    step();
    idle_in();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({LoadValid, Fault, mem_req, ReadData} !== {3'b000, 32'h1234_5678}) begin
        failures++;
        $display("FAIL flush_drop_%0d got=%b/%b/%b/%h exp=0/0/0/12345678", i, LoadValid, Fault,
                 mem_req, ReadData);
      end
      step();
    end
    // Flush in IDLE suppresses both the start and a misaligned fault.
    Valid = 1; MemRead = 1; Funct3 = 3'b000; ALUResult = 32'h0; Flush = 1;
    @(negedge clk);
    step();
    Funct3 = 3'b010; ALUResult = 32'h1;
    @(negedge clk);
    checks++;
    if ({Stall, mem_req, Fault} !== 3'b000) begin
      failures++; $display("FAIL flush_idle got=%b exp=000", {Stall, mem_req, Fault});
    end
    step();
    idle_in();
  endtask

  task automatic test_reset_busy();
    Valid = 1; MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h8;
    step();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL rstbusy_req got=%b exp=1", mem_req);
    end
    step();
    rst_n = 0;
    idle_in();
    #1;
    checks++;
    if ({mem_req, mem_we, mem_be, Stall, Fault, LoadValid, ReadData} !== 41'h0) begin
      failures++;
      $display("FAIL rstbusy_async got=%b/%h exp=0/00000000",
               {mem_req, mem_we, mem_be, Stall, Fault, LoadValid}, ReadData);
    end
    step();
    rst_n = 1;
    step();
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++;
    if ({mem_req, Stall} !== 2'b00) begin
      failures++; $display("FAIL rstbusy_late_ack got=%b exp=00", {mem_req, Stall});
    end
    step();
    mem_ack = 0;
    @(negedge clk);
    checks++;
    if ({LoadValid, mem_req, ReadData} !== {2'b00, 32'h0}) begin
      failures++;
      $display("FAIL rstbusy_after got=%b/%b/%h exp=0/0/00000000", LoadValid, mem_req, ReadData);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_in();
    test_reset();
    test_lb();
    test_sh();
    test_faults();
    test_patterns();
    test_timeout();
    test_flush();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
